// File: rtl/reg_bank_mp.sv
// Multi-read-port register file for the mips789 decode stage.
// Registered write stage with same-cycle bypass, registered read addresses
// with pause/hold, optional hard-zero entry 0, and a hardware clear sequencer
// that zeroes the array after reset or on request.
module reg_bank_mp #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              pause,
  input  logic              rd_clk_cls,
  input  logic              wren,
  input  logic [AW-1:0]     wraddress,
  input  logic [DW-1:0]     data,
  input  logic [NRD*AW-1:0] rdaddress,
  input  logic              clr_req,
  output logic [NRD*DW-1:0] q,
  output logic              busy
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [AW-1:0]   clr_cnt;

  logic            r_wren;
  logic [AW-1:0]   r_wraddress;
  logic [DW-1:0]   r_data;
  logic [AW-1:0]   r_rdaddress [NRD];

  logic [DW-1:0]   mem [DEPTH];

  // Clear FSM state register; reset lands in CLEAR so the array is scrubbed.
  always_ff @(posedge clock or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!rst_n) state <= ST_CLEAR;
    else        state <= state_nxt;
  end

  // Clear FSM next-state: a request starts a sweep, the last entry ends it.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_nxt unassigned
    // (which would infer a latch).
    state_nxt = state;
    case (state)
      ST_IDLE:  if (clr_req) state_nxt = ST_CLEAR;
      ST_CLEAR: if (clr_cnt == {AW{1'b1}}) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Clear FSM outputs.
  always_comb begin
    busy = (state == ST_CLEAR);
  end

  // Sweep pointer: restarted on a new request, advances once per CLEAR cycle
  // and wraps to zero exactly on the exit edge.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n)                          clr_cnt <= '0;
    else if (state == ST_IDLE && clr_req) clr_cnt <= '0;
    else if (state == ST_CLEAR)          clr_cnt <= clr_cnt + 1'b1;
  end

  // Write stage: captures the request unless stalled; requests made while
  // clearing are dropped here.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_wren      <= 1'b0;
      r_wraddress <= '0;
      r_data      <= '0;
    end else if (!pause) begin
      r_wren      <= wren & ~busy;
      r_wraddress <= wraddress;
      r_data      <= data;
    end
  end

  // Read-address registers, frozen by a stall or by the read-port hold.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NRD; k++) r_rdaddress[k] <= '0;
    end else if (!pause && !rd_clk_cls) begin
      for (int k = 0; k < NRD; k++) r_rdaddress[k] <= rdaddress[k*AW +: AW];
    end
  end

  // Array storage: staged write commits, then the sweep zeroes its entry
  // (the sweep wins if both hit the same address on one edge).
  // NOTE: the array deliberately has no reset; the clear sequencer zeroes it
  // so it can still map onto plain RAM/flop arrays without a reset tree.
  always_ff @(posedge clock) begin
    if (r_wren)             mem[r_wraddress] <= r_data;
    if (state == ST_CLEAR)  mem[clr_cnt]     <= '0;
  end

  // Read data per port: clearing, hard-zero entry, bypass, then array.
  always_comb begin
    q = '0;
    for (int k = 0; k < NRD; k++) begin
      if (busy)
        q[k*DW +: DW] = '0;
      else if (ZERO_REG != 0 && r_rdaddress[k] == '0)
        q[k*DW +: DW] = '0;
      else if (r_wren && r_wraddress == r_rdaddress[k])
        q[k*DW +: DW] = r_data;
      else
        q[k*DW +: DW] = mem[r_rdaddress[k]];
    end
  end

endmodule
